// File: rtl/mem_1r1w_fifo_ctrl_pkg.sv
// Shared sizing for the 1R1W-macro FIFO controller; DEPTH/WIDTH/MASK_GRAN must match the attached
// mem_1r1w_masked_32x64 macro.
package mem_fifo_pkg;
    localparam int DEPTH     = 32;
    localparam int WIDTH     = 64;
    localparam int MASK_GRAN = 8;
    localparam int MASK_W    = WIDTH / MASK_GRAN;
    localparam int ADDR_W    = $clog2(DEPTH);
    localparam int CNT_W     = $clog2(DEPTH + 3);

    typedef logic [WIDTH-1:0]  data_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [MASK_W-1:0] mask_t;

    localparam mask_t            MASK_ALL = {MASK_W{1'b1}};
    localparam logic [ADDR_W:0]  MEM_FULL = (ADDR_W + 1)'(DEPTH);
endpackage

// File: rtl/mem_1r1w_fifo_ctrl_if.sv
// Pipeline enqueue/dequeue handshakes plus the macro R0/W0 ports; master is the pipeline/macro
// side, slave is the controller.
interface mem_1r1w_fifo_ctrl_if;
    import mem_fifo_pkg::*;

    logic  in_valid;
    logic  in_ready;
    data_t in_data;
    logic  out_valid;
    logic  out_ready;
    data_t out_data;
    cnt_t  count;
    addr_t mem_R0_addr;
    logic  mem_R0_en;
    data_t mem_R0_data;
    addr_t mem_W0_addr;
    logic  mem_W0_en;
    data_t mem_W0_data;
    mask_t mem_W0_mask;

    modport master (
        output in_valid, in_data, out_ready, mem_R0_data,
        input  in_ready, out_valid, out_data, count,
        input  mem_R0_addr, mem_R0_en, mem_W0_addr, mem_W0_en, mem_W0_data, mem_W0_mask
    );

    modport slave (
        input  in_valid, in_data, out_ready, mem_R0_data,
        output in_ready, out_valid, out_data, count,
        output mem_R0_addr, mem_R0_en, mem_W0_addr, mem_W0_en, mem_W0_data, mem_W0_mask
    );
endinterface

// File: rtl/mem_1r1w_fifo_ctrl_out_buf.sv
// 2-entry output FIFO absorbing the macro read latency; head visible combinationally, push lands
// at the clock edge. Caller guarantees no push when full.
module fifo_out_buf
    import mem_fifo_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  data_t      data_in,
    output data_t      data_out,
    output logic [1:0] cnt
);
    data_t      ent_q [2];
    data_t      ent_d [2];
    logic       wr_q, wr_d;
    logic       rd_q, rd_d;
    logic [1:0] cnt_q, cnt_d;

    always_comb begin
        ent_d = ent_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
        if (push) begin
            ent_d[wr_q] = data_in;
            wr_d        = ~wr_q;
        end
        if (pop) begin
            rd_d = ~rd_q;
        end
        if (flush) begin
            wr_d  = 1'b0;
            rd_d  = 1'b0;
            cnt_d = 2'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Payload needs no reset: cnt_q gates every use of it.
    always_ff @(posedge clock) begin
        ent_q <= ent_d;
    end

    assign data_out = ent_q[rd_q];
    assign cnt      = cnt_q;
endmodule

// File: rtl/mem_1r1w_fifo_ctrl.sv
// FWFT FIFO over an external 1R1W macro, capacity DEPTH+2; enqueue-to-out_valid latency 3 cycles.
// in_ready drops when the macro holds DEPTH entries; 1 beat/cycle sustained both ways.
module mem_1r1w_fifo_ctrl
    import mem_fifo_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    mem_1r1w_fifo_ctrl_if.slave  bus
);
    addr_t           wptr_q, wptr_d;
    addr_t           rptr_q, rptr_d;
    logic [ADDR_W:0] mem_cnt_q, mem_cnt_d;
    logic            inflight_q, inflight_d;
    cnt_t            count_q, count_d;
    logic [1:0]      buf_cnt;
    logic [2:0]      buf_occ;
    data_t           buf_head;
    logic            enq_fire;
    logic            deq_fire;
    logic            rd_issue;

    assign bus.in_ready = !reset && !flush && (mem_cnt_q < MEM_FULL);
    assign enq_fire     = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (buf_cnt != 2'd0);
    assign deq_fire     = bus.out_valid && bus.out_ready;

    // Buffer slots still committed after this cycle's pop; issuing keeps that below 2 so the
    // returning read always has a slot. mem_cnt_q is registered, so a just-written entry is
    // never read in its write cycle.
    assign buf_occ  = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, deq_fire};
    assign rd_issue = (mem_cnt_q != '0) && (buf_occ < 3'd2) && !flush && !reset;

    always_comb begin
        wptr_d     = wptr_q + ADDR_W'(enq_fire);
        rptr_d     = rptr_q + ADDR_W'(rd_issue);
        mem_cnt_d  = mem_cnt_q + (ADDR_W + 1)'(enq_fire) - (ADDR_W + 1)'(rd_issue);
        inflight_d = rd_issue;
        count_d    = count_q + CNT_W'(enq_fire) - CNT_W'(deq_fire);
        if (flush) begin
            wptr_d     = '0;
            rptr_d     = '0;
            mem_cnt_d  = '0;
            inflight_d = 1'b0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            mem_cnt_q  <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            mem_cnt_q  <= mem_cnt_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
        end
    end

    fifo_out_buf u_buf (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .push     (inflight_q),
        .pop      (deq_fire),
        .data_in  (bus.mem_R0_data),
        .data_out (buf_head),
        .cnt      (buf_cnt)
    );

    assign bus.out_data    = buf_head;
    assign bus.count       = count_q;
    assign bus.mem_W0_en   = enq_fire;
    assign bus.mem_W0_addr = wptr_q;
    assign bus.mem_W0_data = bus.in_data;
    assign bus.mem_W0_mask = enq_fire ? MASK_ALL : '0;
    assign bus.mem_R0_en   = rd_issue;
    assign bus.mem_R0_addr = rptr_q;
endmodule

// File: tb/tb_mem_1r1w_fifo_ctrl.sv
// Directed + random bench for mem_1r1w_fifo_ctrl with a behavioural macro model and a data scoreboard.
module tb_mem_1r1w_fifo_ctrl;
    import mem_fifo_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;

    mem_1r1w_fifo_ctrl_if bus();

    mem_1r1w_fifo_ctrl dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Macro model: masked write, registered read data the cycle after the enable.
    data_t macro_q [DEPTH];
    always @(posedge clock) begin
        if (bus.mem_W0_en) begin
            for (int b = 0; b < MASK_W; b++) begin
                if (bus.mem_W0_mask[b])
                    macro_q[bus.mem_W0_addr][b*MASK_GRAN +: MASK_GRAN] <= bus.mem_W0_data[b*MASK_GRAN +: MASK_GRAN];
            end
        end
        if (bus.mem_R0_en)
            bus.mem_R0_data <= macro_q[bus.mem_R0_addr];
    end

    int    checks   = 0;
    int    failures = 0;
    data_t sb [$];

    logic  s_in_ready, s_out_valid, s_w_en, s_r_en, s_enq, s_deq;
    data_t s_out_data, s_w_data;
    addr_t s_w_addr, s_r_addr;
    mask_t s_w_mask;
    cnt_t  s_count;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive after the falling edge, sample 1ns later, update the scoreboard.
    task automatic step(input logic iv, input data_t d, input logic ordy, input logic fl);
        data_t exp;
        @(negedge clock);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        flush         = fl;
        #1;
        s_in_ready  = bus.in_ready;
        s_out_valid = bus.out_valid;
        s_out_data  = bus.out_data;
        s_w_en      = bus.mem_W0_en;
        s_w_addr    = bus.mem_W0_addr;
        s_w_data    = bus.mem_W0_data;
        s_w_mask    = bus.mem_W0_mask;
        s_r_en      = bus.mem_R0_en;
        s_r_addr    = bus.mem_R0_addr;
        s_count     = bus.count;
        s_enq       = iv && bus.in_ready;
        s_deq       = bus.out_valid && ordy;

        check("count", 64'(s_count), 64'(sb.size()));
        check("buf_bound", 64'(dut.buf_cnt <= 2'd2), 64'd1);
        check("w_en", 64'(s_w_en), 64'(s_enq));
        check("mask", 64'(s_w_mask), s_w_en ? 64'hFF : 64'h0);
        check("out_valid_empty", 64'(s_out_valid && (sb.size() == 0)), 64'd0);
        if (s_enq)
            check("w_data", s_w_data, d);
        if (s_w_en && s_r_en)
            check("rw_collide", 64'(s_w_addr != s_r_addr), 64'd1);
        if (s_deq && sb.size() > 0) begin
            exp = sb.pop_front();
            check("out_data", s_out_data, exp);
        end
        if (s_enq)
            sb.push_back(d);
        if (fl)
            sb.delete();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset         = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #1;
        check("rst_in_ready_low", 64'(bus.in_ready), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        sb.delete();
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_r_en", 64'(bus.mem_R0_en), 64'd0);
        check("rst_w_en", 64'(bus.mem_W0_en), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int got, gaps, early, enq, cycles;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.out_ready   = 1'b0;
        bus.mem_R0_data = '0;

        // Reset then a single beat through an empty FIFO.
        do_reset();
        step(1'b1, 64'hDEAD_BEEF_0000_0001, 1'b1, 1'b0);
        check("single_w_en", 64'(s_w_en), 64'd1);
        check("single_w_addr", 64'(s_w_addr), 64'd0);
        check("single_w_mask", 64'(s_w_mask), 64'hFF);
        step(1'b0, '0, 1'b1, 1'b0);
        check("single_r_en", 64'(s_r_en), 64'd1);
        check("single_r_addr", 64'(s_r_addr), 64'd0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("single_n2_valid", 64'(s_out_valid), 64'd0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("single_n3_valid", 64'(s_out_valid), 64'd1);
        check("single_n3_data", s_out_data, 64'hDEAD_BEEF_0000_0001);
        step(1'b0, '0, 1'b1, 1'b0);
        check("single_count_back", 64'(s_count), 64'd0);

        // Fill to DEPTH+2 with the output stalled, then drain.
        do_reset();
        got = 0;
        for (int i = 0; i < 34; i++) begin
            step(1'b1, 64'(i), 1'b0, 1'b0);
            if (s_enq) got++;
        end
        check("fill_accepts", 64'(got), 64'd34);
        step(1'b1, 64'hBAD, 1'b0, 1'b0);
        check("full_in_ready", 64'(s_in_ready), 64'd0);
        check("full_count", 64'(s_count), 64'd34);
        got  = 0;
        gaps = 0;
        for (int c = 0; c < 60 && got < 34; c++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            if (s_deq) got++;
            else if (got > 0) gaps++;
        end
        check("drain_count", 64'(got), 64'd34);
        check("drain_gaps", 64'(gaps), 64'd0);

        // Streaming 100 beats with pointer wrap.
        do_reset();
        got   = 0;
        gaps  = 0;
        early = 0;
        for (int i = 0; i < 106; i++) begin
            step(i < 100, 64'(i) + 64'h1000, 1'b1, 1'b0);
            if (s_deq) got++;
            if (i < 3 && s_out_valid) early++;
            if (i >= 3 && i < 103 && !s_out_valid) gaps++;
            if (i == 31 || i == 32)
                check("stream_w_addr", 64'(s_w_addr), 64'(i % DEPTH));
            if (i == 32 || i == 33)
                check("stream_r_addr", 64'(s_r_addr), 64'((i - 1) % DEPTH));
        end
        check("stream_deq", 64'(got), 64'd100);
        check("stream_gaps", 64'(gaps), 64'd0);
        check("stream_early", 64'(early), 64'd0);

        // Random valid/ready, 2000 accepted beats.
        do_reset();
        enq    = 0;
        cycles = 0;
        while (enq < 2000 && cycles < 20000) begin
            step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0);
            if (s_enq) enq++;
            cycles++;
        end
        check("rand_enq", 64'(enq), 64'd2000);
        for (int c = 0; c < 100 && sb.size() > 0; c++)
            step(1'b0, '0, 1'b1, 1'b0);
        check("rand_drained", 64'(sb.size()), 64'd0);

        // Flush with 10 held and a read in flight.
        do_reset();
        for (int i = 0; i < 10; i++)
            step(1'b1, 64'h77 + 64'(i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("pre_flush_r_en", 64'(s_r_en), 64'd1);
        step(1'b1, 64'hBAD, 1'b0, 1'b1);
        check("flush_in_ready", 64'(s_in_ready), 64'd0);
        check("flush_r_en", 64'(s_r_en), 64'd0);
        step(1'b1, 64'h5, 1'b1, 1'b0);
        check("post_flush_count", 64'(s_count), 64'd0);
        check("post_flush_valid", 64'(s_out_valid), 64'd0);
        check("post_flush_w_en", 64'(s_w_en), 64'd1);
        got = 0;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            if (s_out_valid) got++;
        end
        check("post_flush_no_stale", 64'(got), 64'd0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("post_flush_n3_valid", 64'(s_out_valid), 64'd1);
        check("post_flush_n3_data", s_out_data, 64'h5);
        step(1'b0, '0, 1'b1, 1'b0);
        check("post_flush_empty", 64'(s_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
